// File: rtl/tag_ram_pkg.sv
// rtl/tag_ram_pkg.sv - shared types and width helpers for the tag RAM controller
package tag_ram_pkg;

   typedef enum logic [1:0] {
      ST_INIT = 2'd0,
      ST_IDLE = 2'd1,
      ST_LOOK = 2'd2
   } state_t;

   // Requester slots on the arbiter: bit 0 lookup, bit 1 update.
   localparam int REQ_LK = 0;
   localparam int REQ_UP = 1;

   function automatic int vbit_of(input int dwidth);
      return dwidth - 1;
   endfunction

   function automatic int tag_w_of(input int dwidth);
      return dwidth - 1;
   endfunction

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin arbiter; priority passes to the loser on every grant
module rr_arb2 (
   input  logic       clock,
   input  logic       rst_n,
   input  logic       en,
   input  logic [1:0] req,
   output logic [1:0] gnt
);

   logic prio;

   always_comb begin
      gnt = 2'b00;
      if (en) begin
         if (req == 2'b11) gnt = prio ? 2'b10 : 2'b01;
         else              gnt = req;
      end
   end

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n)      prio <= 1'b0;
      else if (gnt[0]) prio <= 1'b1;
      else if (gnt[1]) prio <= 1'b0;
   end

endmodule

// File: rtl/tag_ram_ctrl.sv
// rtl/tag_ram_ctrl.sv - shares one sync-read tag RAM between a lookup port and an update port
module tag_ram_ctrl
   import tag_ram_pkg::*;
#(
   parameter int AWIDTH     = 3,
   parameter int DWIDTH     = 14,
   parameter bit INIT_CLEAR = 1'b1
) (
   input  logic              clock,
   input  logic              rst_n,
   input  logic              lk_valid,
   output logic              lk_ready,
   input  logic [AWIDTH-1:0] lk_index,
   input  logic [DWIDTH-2:0] lk_tag,
   output logic              rsp_valid,
   output logic              rsp_hit,
   output logic [DWIDTH-2:0] rsp_tag,
   input  logic              up_valid,
   output logic              up_ready,
   input  logic [AWIDTH-1:0] up_index,
   input  logic [DWIDTH-2:0] up_tag,
   input  logic              up_vbit,
   output logic              init_done,
   output logic [AWIDTH-1:0] ram_addr,
   output logic [DWIDTH-1:0] ram_din,
   output logic              ram_we,
   input  logic [DWIDTH-1:0] ram_dout
);

   localparam int VBIT  = vbit_of(DWIDTH);
   localparam int TAG_W = tag_w_of(DWIDTH);

   state_t            state;
   logic [AWIDTH-1:0] cnt;
   logic [TAG_W-1:0]  tag_q;
   logic [1:0]        gnt;

   rr_arb2 u_arb (
      .clock (clock),
      .rst_n (rst_n),
      .en    (state == ST_IDLE),
      .req   ({up_valid, lk_valid}),
      .gnt   (gnt)
   );

   assign lk_ready = gnt[REQ_LK];
   assign up_ready = gnt[REQ_UP];

   // RAM port is steered combinationally so a grant reaches the RAM in the same cycle.
   always_comb begin
      ram_we   = 1'b0;
      ram_addr = lk_index;
      ram_din  = {up_vbit, up_tag};
      if (state == ST_INIT) begin
         ram_we   = 1'b1;
         ram_addr = cnt;
         ram_din  = '0;
      end else if (gnt[REQ_UP]) begin
         ram_we   = 1'b1;
         ram_addr = up_index;
      end
   end

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         state     <= INIT_CLEAR ? ST_INIT : ST_IDLE;
         cnt       <= '0;
         init_done <= !INIT_CLEAR;
         tag_q     <= '0;
         rsp_valid <= 1'b0;
         rsp_hit   <= 1'b0;
         rsp_tag   <= '0;
      end else begin
         rsp_valid <= 1'b0;
         case (state)
            ST_INIT: begin
               cnt <= cnt + 1'b1;
               if (cnt == {AWIDTH{1'b1}}) begin
                  state     <= ST_IDLE;
                  init_done <= 1'b1;
               end
            end
            ST_IDLE: begin
               if (gnt[REQ_LK]) begin
                  tag_q <= lk_tag;
                  state <= ST_LOOK;
               end
            end
            ST_LOOK: begin
               rsp_valid <= 1'b1;
               rsp_hit   <= ram_dout[VBIT] && (ram_dout[TAG_W-1:0] == tag_q);
               rsp_tag   <= ram_dout[TAG_W-1:0];
               state     <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_tag_ram_ctrl.sv
// tb/tb_tag_ram_ctrl.sv - directed self-checking bench for tag_ram_ctrl with a behavioural tag RAM
module tb_tag_ram_ctrl;

   logic        clock;
   logic        rst_n;
   logic        lk_valid;
   logic        lk_ready;
   logic [2:0]  lk_index;
   logic [12:0] lk_tag;
   logic        rsp_valid;
   logic        rsp_hit;
   logic [12:0] rsp_tag;
   logic        up_valid;
   logic        up_ready;
   logic [2:0]  up_index;
   logic [12:0] up_tag;
   logic        up_vbit;
   logic        init_done;
   logic [2:0]  ram_addr;
   logic [13:0] ram_din;
   logic        ram_we;
   logic [13:0] ram_dout;

   int errors = 0;
   int checks = 0;

   logic [13:0] mem [0:7];

   tag_ram_ctrl #(.AWIDTH(3), .DWIDTH(14), .INIT_CLEAR(1'b1)) dut (
      .clock     (clock),
      .rst_n     (rst_n),
      .lk_valid  (lk_valid),
      .lk_ready  (lk_ready),
      .lk_index  (lk_index),
      .lk_tag    (lk_tag),
      .rsp_valid (rsp_valid),
      .rsp_hit   (rsp_hit),
      .rsp_tag   (rsp_tag),
      .up_valid  (up_valid),
      .up_ready  (up_ready),
      .up_index  (up_index),
      .up_tag    (up_tag),
      .up_vbit   (up_vbit),
      .init_done (init_done),
      .ram_addr  (ram_addr),
      .ram_din   (ram_din),
      .ram_we    (ram_we),
      .ram_dout  (ram_dout)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   always @(posedge clock) begin
      if (ram_we) mem[ram_addr] <= ram_din;
      ram_dout <= mem[ram_addr];
   end

   // Tasks start and end at negedge+1, after inputs have settled.
   task automatic do_update(input logic [2:0] idx, input logic [12:0] tag, input logic vb);
      int n;
      up_valid = 1'b1; up_index = idx; up_tag = tag; up_vbit = vb;
      #1;
      n = 0;
      while (!up_ready && n < 20) begin
         @(negedge clock); #1; n++;
      end
      if (!up_ready) begin
         errors++; checks++;
         $display("FAIL update_timeout idx=%0d up_ready=%b required 1", idx, up_ready);
      end
      @(negedge clock);
      up_valid = 1'b0;
      #1;
   endtask

   task automatic do_lookup(input logic [2:0] idx, input logic [12:0] tag,
                            output logic v, output logic hit, output logic [12:0] t);
      int n;
      lk_valid = 1'b1; lk_index = idx; lk_tag = tag;
      #1;
      n = 0;
      while (!lk_ready && n < 20) begin
         @(negedge clock); #1; n++;
      end
      if (!lk_ready) begin
         errors++; checks++;
         $display("FAIL lookup_timeout idx=%0d lk_ready=%b required 1", idx, lk_ready);
      end
      @(negedge clock);
      lk_valid = 1'b0;
      #1;
      @(negedge clock); #1;
      v = rsp_valid; hit = rsp_hit; t = rsp_tag;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      lk_valid = 1'b1; up_valid = 1'b1;
      lk_index = '0; lk_tag = '0; up_index = '0; up_tag = '0; up_vbit = 1'b0;
      repeat (2) @(negedge clock);
      #1;
      checks++;
      if ({lk_ready, up_ready, rsp_valid, rsp_hit, rsp_tag, init_done} !== 18'b0) begin
         errors++;
         $display("FAIL reset_values got=%b required 0", {lk_ready, up_ready, rsp_valid, rsp_hit, rsp_tag, init_done});
      end
      @(negedge clock);
      rst_n = 1'b1;
      #1;
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (ram_we !== 1'b1 || ram_addr !== 3'(i) || ram_din !== 14'd0 ||
             lk_ready !== 1'b0 || up_ready !== 1'b0 || init_done !== 1'b0) begin
            errors++;
            $display("FAIL init_sweep cyc=%0d we=%b addr=%0d din=%h rdy=%b%b done=%b required we=1 addr=%0d din=0 rdy=00 done=0",
                     i, ram_we, ram_addr, ram_din, lk_ready, up_ready, init_done, i);
         end
         if (i == 7) begin
            lk_valid = 1'b0; up_valid = 1'b0;
         end
         @(negedge clock); #1;
      end
      checks++;
      if (init_done !== 1'b1 || ram_we !== 1'b0) begin
         errors++;
         $display("FAIL init_done got done=%b we=%b required done=1 we=0", init_done, ram_we);
      end
   endtask

   task automatic test_update_lookup();
      logic v, h;
      logic [12:0] t;
      do_update(3'd3, 13'h0A5, 1'b1);
      do_lookup(3'd3, 13'h0A5, v, h, t);
      checks++;
      if (v !== 1'b1 || h !== 1'b1 || t !== 13'h0A5) begin
         errors++;
         $display("FAIL hit_after_update got v=%b hit=%b tag=%h required v=1 hit=1 tag=0a5", v, h, t);
      end
      @(negedge clock); #1;
      checks++;
      if (rsp_valid !== 1'b0 || rsp_tag !== 13'h0A5) begin
         errors++;
         $display("FAIL rsp_one_cycle got v=%b tag=%h required v=0 tag=0a5", rsp_valid, rsp_tag);
      end
   endtask

   task automatic test_miss_invalidate();
      logic v, h;
      logic [12:0] t;
      do_lookup(3'd3, 13'h0A6, v, h, t);
      checks++;
      if (v !== 1'b1 || h !== 1'b0 || t !== 13'h0A5) begin
         errors++;
         $display("FAIL tag_miss got v=%b hit=%b tag=%h required v=1 hit=0 tag=0a5", v, h, t);
      end
      do_update(3'd3, 13'h0A5, 1'b0);
      do_lookup(3'd3, 13'h0A5, v, h, t);
      checks++;
      if (v !== 1'b1 || h !== 1'b0 || t !== 13'h0A5) begin
         errors++;
         $display("FAIL invalidated got v=%b hit=%b tag=%h required v=1 hit=0 tag=0a5", v, h, t);
      end
      do_lookup(3'd5, 13'h000, v, h, t);
      checks++;
      if (v !== 1'b1 || h !== 1'b0 || t !== 13'h000) begin
         errors++;
         $display("FAIL cleared_entry got v=%b hit=%b tag=%h required v=1 hit=0 tag=000", v, h, t);
      end
   endtask

   task automatic test_round_robin();
      logic [5:0] exp_lk;
      logic [5:0] exp_up;
      logic [5:0] exp_rv;
      exp_lk = 6'b001001;
      exp_up = 6'b100100;
      exp_rv = 6'b100100;
      // Last grant is an update, so lookup holds priority next.
      do_update(3'd6, 13'h1FFF, 1'b1);
      lk_valid = 1'b1; lk_index = 3'd6; lk_tag = 13'h1FFF;
      up_valid = 1'b1; up_index = 3'd2; up_tag = 13'h0111; up_vbit = 1'b1;
      #1;
      for (int c = 0; c < 6; c++) begin
         checks++;
         if (lk_ready !== exp_lk[c] || up_ready !== exp_up[c] || rsp_valid !== exp_rv[c]) begin
            errors++;
            $display("FAIL rr_grant cyc=%0d got lk=%b up=%b rv=%b required lk=%b up=%b rv=%b",
                     c, lk_ready, up_ready, rsp_valid, exp_lk[c], exp_up[c], exp_rv[c]);
         end
         if (exp_rv[c] && (rsp_hit !== 1'b1 || rsp_tag !== 13'h1FFF)) begin
            errors++;
            $display("FAIL rr_rsp cyc=%0d got hit=%b tag=%h required hit=1 tag=1fff", c, rsp_hit, rsp_tag);
         end
         @(negedge clock); #1;
      end
      lk_valid = 1'b0; up_valid = 1'b0;
      #1;
   endtask

   task automatic test_back_to_back();
      logic [5:0] exp_lk;
      logic [5:0] exp_rv;
      exp_lk = 6'b010101;
      exp_rv = 6'b010100;
      lk_valid = 1'b1; lk_index = 3'd2; lk_tag = 13'h0111;
      #1;
      for (int c = 0; c < 6; c++) begin
         checks++;
         if (lk_ready !== exp_lk[c] || up_ready !== 1'b0 || rsp_valid !== exp_rv[c]) begin
            errors++;
            $display("FAIL b2b cyc=%0d got lk=%b up=%b rv=%b required lk=%b up=0 rv=%b",
                     c, lk_ready, up_ready, rsp_valid, exp_lk[c], exp_rv[c]);
         end
         if (exp_rv[c] && (rsp_hit !== 1'b1 || rsp_tag !== 13'h0111)) begin
            errors++;
            $display("FAIL b2b_rsp cyc=%0d got hit=%b tag=%h required hit=1 tag=0111", c, rsp_hit, rsp_tag);
         end
         @(negedge clock); #1;
      end
      lk_valid = 1'b0;
      #1;
      @(negedge clock); #1;
   endtask

   task automatic test_reset_in_look();
      logic v, h;
      logic [12:0] t;
      int n;
      lk_valid = 1'b1; lk_index = 3'd6; lk_tag = 13'h1FFF;
      #1;
      n = 0;
      while (!lk_ready && n < 20) begin
         @(negedge clock); #1; n++;
      end
      @(negedge clock);
      lk_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      checks++;
      if (rsp_valid !== 1'b0 || rsp_hit !== 1'b0 || rsp_tag !== 13'd0 || init_done !== 1'b0 ||
          lk_ready !== 1'b0 || up_ready !== 1'b0 || ram_addr !== 3'd0 || ram_we !== 1'b1) begin
         errors++;
         $display("FAIL reset_in_look got rv=%b hit=%b tag=%h done=%b rdy=%b%b addr=%0d we=%b required rv=0 hit=0 tag=0 done=0 rdy=00 addr=0 we=1",
                  rsp_valid, rsp_hit, rsp_tag, init_done, lk_ready, up_ready, ram_addr, ram_we);
      end
      @(negedge clock); #1;
      checks++;
      if (rsp_valid !== 1'b0) begin
         errors++;
         $display("FAIL dropped_rsp got rv=%b required 0", rsp_valid);
      end
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (ram_we !== 1'b1 || ram_addr !== 3'(i) || init_done !== 1'b0 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL resweep cyc=%0d we=%b addr=%0d done=%b rv=%b required we=1 addr=%0d done=0 rv=0",
                     i, ram_we, ram_addr, init_done, rsp_valid, i);
         end
         @(negedge clock); #1;
      end
      checks++;
      if (init_done !== 1'b1) begin
         errors++;
         $display("FAIL resweep_done got %b required 1", init_done);
      end
      do_lookup(3'd6, 13'h1FFF, v, h, t);
      checks++;
      if (v !== 1'b1 || h !== 1'b0 || t !== 13'h000) begin
         errors++;
         $display("FAIL cleared_after_reset got v=%b hit=%b tag=%h required v=1 hit=0 tag=000", v, h, t);
      end
   endtask

   initial begin
      for (int i = 0; i < 8; i++) mem[i] = 14'h3FFF;
      ram_dout = '0;
      test_reset();
      test_update_lookup();
      test_miss_invalidate();
      test_round_robin();
      test_back_to_back();
      test_reset_in_look();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
